data_cache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache; the responder on the CPU data-memory port (DATA_MEM_READ/WRITE/ADDR/WRITE_DATA/READ_DATA/BUSYWAIT).
- Backs onto a 128-bit block-wide main-memory port.
- Performs RV32IM load sign/zero extension and store byte-lane merging.
- Stalls the pipeline via DATA_MEM_BUSYWAIT on misses.

---
 rtl/data_cache_controller_if.sv | 33 +++
 rtl/data_cache_controller.sv | 136 +++++++++++++
 tb/tb_data_cache_controller.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_controller_if.sv
// CPU data-port and 128-bit main-memory port of the data cache, bundled.
// Latency: none (signal bundle only).
// Backpressure: DATA_MEM_BUSYWAIT stalls the CPU, MEM_BUSYWAIT stalls the cache.
interface data_cache_controller_if;
   logic [3:0]   DATA_MEM_READ;
   logic [2:0]   DATA_MEM_WRITE;
   logic [31:0]  DATA_MEM_ADDR;
   logic [31:0]  DATA_MEM_WRITE_DATA;
   logic [31:0]  DATA_MEM_READ_DATA;
   logic         DATA_MEM_BUSYWAIT;
   logic         MEM_READ;
   logic         MEM_WRITE;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_WRITEDATA;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   // cache side
   modport slave (
      input  DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
      output DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT,
      output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
      input  MEM_READDATA, MEM_BUSYWAIT
   );

   // CPU + main-memory side
   modport master (
      output DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
      input  DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT,
      input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
      output MEM_READDATA, MEM_BUSYWAIT
   );
endinterface

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back/write-allocate data cache with RV32 load extension and store merge.
// Latency: hits respond combinationally; a clean miss stalls 2+ cycles, a dirty miss adds a writeback.
// Backpressure: BUSYWAIT held on any miss until refill; MEM_BUSYWAIT stretches each block transfer.
module data_cache_controller #(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 25
) (
   input logic CLK,
   input logic RESET,
   data_cache_controller_if.slave bus
);
   localparam int LINES = 1 << INDEX_BITS;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] ALLOCATE  = 2'd2;

   logic [1:0] state, state_nxt;

   logic [LINES-1:0]    valid, dirty;
   logic [TAG_BITS-1:0] tag_arr  [LINES];
   logic [127:0]        data_arr [LINES];

   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_idx;
   logic [1:0]            req_word, req_byte;
   logic                  rd_en, wr_en, access, hit;
   logic                  write_hit, fill_done;
   logic [127:0]          line, merged_line;
   logic [31:0]           word, ext_data, st_data;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [3:0]            st_mask;

   assign req_tag  = bus.DATA_MEM_ADDR[31:4+INDEX_BITS];
   assign req_idx  = bus.DATA_MEM_ADDR[3+INDEX_BITS:4];
   assign req_word = bus.DATA_MEM_ADDR[3:2];
   assign req_byte = bus.DATA_MEM_ADDR[1:0];

   // a request with both enables set behaves as a store
   assign rd_en  = bus.DATA_MEM_READ[3];
   assign wr_en  = bus.DATA_MEM_WRITE[2];
   assign access = rd_en | wr_en;
   assign hit    = valid[req_idx] && (tag_arr[req_idx] == req_tag);

   assign line    = data_arr[req_idx];
   assign word    = line[{req_word, 5'd0} +: 32];
   assign ld_byte = word[{req_byte, 3'd0} +: 8];
   assign ld_half = word[{bus.DATA_MEM_ADDR[1], 4'd0} +: 16];

   assign write_hit = (state == IDLE) && wr_en && hit;
   assign fill_done = (state == ALLOCATE) && !bus.MEM_BUSYWAIT;

   // load extension by funct3; unused codes read as zero
   always_comb begin
      ext_data = 32'd0;
      case (bus.DATA_MEM_READ[2:0])
         3'b000:  ext_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ext_data = {{16{ld_half[15]}}, ld_half};
         3'b010:  ext_data = word;
         3'b100:  ext_data = {24'd0, ld_byte};
         3'b101:  ext_data = {16'd0, ld_half};
         default: ext_data = 32'd0;
      endcase
   end

   // store byte-lane selection and merge into the addressed word of the line
   always_comb begin
      st_mask = 4'b0000;
      st_data = bus.DATA_MEM_WRITE_DATA;
      case (bus.DATA_MEM_WRITE[1:0])
         2'b00: begin
            st_mask = 4'b0001 << req_byte;
            st_data = {4{bus.DATA_MEM_WRITE_DATA[7:0]}};
         end
         2'b01: begin
            st_mask = bus.DATA_MEM_ADDR[1] ? 4'b1100 : 4'b0011;
            st_data = {2{bus.DATA_MEM_WRITE_DATA[15:0]}};
         end
         2'b10:   st_mask = 4'b1111;
         default: st_mask = 4'b0000;
      endcase
      merged_line = line;
      for (int b = 0; b < 4; b++) begin
         if (st_mask[b]) merged_line[32*int'(req_word) + 8*b +: 8] = st_data[8*b +: 8];
      end
   end

   // miss handling: write back a dirty victim first, then refill
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (access && !hit)
               state_nxt = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: if (!bus.MEM_BUSYWAIT) state_nxt = ALLOCATE;
         ALLOCATE:  if (!bus.MEM_BUSYWAIT) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // FSM and line status bits; reset invalidates everything and aborts transfers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_nxt;
         if (write_hit) dirty[req_idx] <= 1'b1;
         if (fill_done) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
         end
      end
   end

   // tag/data storage is never cleared; its contents are qualified by valid
   always_ff @(posedge CLK) begin
      if (write_hit) begin
         data_arr[req_idx] <= merged_line;
      end else if (fill_done) begin
         data_arr[req_idx] <= bus.MEM_READDATA;
         tag_arr[req_idx]  <= req_tag;
      end
   end

   assign bus.DATA_MEM_BUSYWAIT  = RESET && ((state != IDLE) || (access && !hit));
   assign bus.DATA_MEM_READ_DATA = (RESET && state == IDLE && rd_en && !wr_en && hit) ? ext_data : 32'd0;
   assign bus.MEM_WRITE          = (state == WRITEBACK);
   assign bus.MEM_READ           = (state == ALLOCATE);
   assign bus.MEM_ADDRESS        = (state == WRITEBACK) ? {tag_arr[req_idx], req_idx}
                                                        : bus.DATA_MEM_ADDR[31:4];
   assign bus.MEM_WRITEDATA      = line;
endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized scoreboard bench for data_cache_controller against a flat-memory reference model.
// Latency: expected loads, writebacks and refills are queued at issue and popped on completion.
// Backpressure: the memory responder inserts configurable or random busy cycles per transfer.
module tb_data_cache_controller;
   typedef enum int {K_WB, K_FILL, K_LOAD} kind_t;
   typedef struct {
      kind_t        kind;
      logic [27:0]  blk;
      logic [127:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_cache_controller_if bus();

   data_cache_controller #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cfg = -1;

   exp_t         sb[$];
   logic [127:0] mem_line [logic [27:0]];   // main memory contents
   logic [127:0] ref_mem  [logic [27:0]];   // architecturally visible contents
   bit           m_valid [8];
   bit           m_dirty [8];
   logic [27:0]  m_blk   [8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [127:0] init_line(input logic [27:0] b);
      logic [127:0] l;
      for (int i = 0; i < 4; i++)
         l[i*32 +: 32] = ({4'h0, b} * 32'h9E3779B1) ^ (32'h1234_5678 * 32'(i + 1));
      return l;
   endfunction

   function automatic logic [127:0] mem_get(input logic [27:0] b);
      return mem_line.exists(b) ? mem_line[b] : init_line(b);
   endfunction

   function automatic logic [127:0] ref_get(input logic [27:0] b);
      return ref_mem.exists(b) ? ref_mem[b] : mem_get(b);
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [127:0] l, input int o);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      b = l[o*8 +: 8];
      h = l[(o/2)*16 +: 16];
      w = l[(o/4)*32 +: 32];
      case (f3)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd2:    return w;
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

   function automatic int pick_busy();
      return (busy_cfg >= 0) ? busy_cfg : int'($urandom_range(0, 3));
   endfunction

   // reference model: direct-mapped placement decides writebacks/refills; data from flat view
   task automatic model_issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd);
      logic [27:0]  blk;
      logic [127:0] l;
      int           idx, o;
      exp_t         e;
      blk = a[31:4];
      idx = int'(a[6:4]);
      o   = int'(a[3:0]);
      if (!(m_valid[idx] && m_blk[idx] == blk)) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            e.kind = K_WB; e.blk = m_blk[idx]; e.data = ref_get(m_blk[idx]);
            sb.push_back(e);
         end
         e.kind = K_FILL; e.blk = blk; e.data = '0;
         sb.push_back(e);
         m_valid[idx] = 1'b1; m_blk[idx] = blk; m_dirty[idx] = 1'b0;
      end
      if (wr) begin
         l = ref_get(blk);
         case (sz)
            2'd0:    l[o*8 +: 8]         = wd[7:0];
            2'd1:    l[(o/2)*16 +: 16]   = wd[15:0];
            default: l[(o/4)*32 +: 32]   = wd;
         endcase
         ref_mem[blk] = l;
         m_dirty[idx] = 1'b1;
      end else if (rd) begin
         e.kind = K_LOAD; e.blk = blk; e.data = {96'd0, load_val(f3, ref_get(blk), o)};
         sb.push_back(e);
      end
   endtask

   // reset discards dirty lines: the visible view falls back to main memory
   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         if (m_valid[i] && ref_mem.exists(m_blk[i])) ref_mem.delete(m_blk[i]);
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      sb.delete();
   endtask

   task automatic drive_idle();
      bus.DATA_MEM_READ       = 4'd0;
      bus.DATA_MEM_WRITE      = 3'd0;
      bus.DATA_MEM_ADDR       = 32'd0;
      bus.DATA_MEM_WRITE_DATA = 32'd0;
   endtask

   task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int waits, output logic [31:0] rdat);
      bit done;
      model_issue(rd, wr, f3, sz, a, wd);
      @(posedge clk); #1;
      bus.DATA_MEM_READ       = {rd, f3};
      bus.DATA_MEM_WRITE      = {wr, sz};
      bus.DATA_MEM_ADDR       = a;
      bus.DATA_MEM_WRITE_DATA = wd;
      waits = 0; done = 1'b0; rdat = 32'd0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk); #1;
         if (!bus.DATA_MEM_BUSYWAIT) begin
            rdat = bus.DATA_MEM_READ_DATA;
            done = 1'b1;
            break;
         end
         waits++;
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL access_timeout: addr %h still stalled after %0d cycles, expected completion", a, waits);
      end
   endtask

   task automatic pop_check(input kind_t k, input logic [27:0] a, input logic [127:0] d);
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL sb_unexpected: got kind %0d addr %h data %h, expected nothing", k, a, d);
         return;
      end
      e = sb.pop_front();
      if (e.kind != k || (k != K_LOAD && e.blk != a) || (k != K_FILL && e.data != d)) begin
         n_fail++;
         $display("FAIL sb_compare: got kind %0d addr %h data %h, expected kind %0d addr %h data %h",
                  k, a, d, e.kind, e.blk, e.data);
      end
   endtask

   // main-memory responder: holds MEM_BUSYWAIT for N cycles per transfer
   initial begin
      int busy_left;
      busy_left = 0;
      bus.MEM_BUSYWAIT = 1'b0;
      bus.MEM_READDATA = '0;
      forever begin
         @(negedge clk);
         if (!rst_n || !(bus.MEM_READ || bus.MEM_WRITE)) begin
            bus.MEM_BUSYWAIT = 1'b0;
            busy_left = pick_busy();
         end else if (busy_left > 0) begin
            bus.MEM_BUSYWAIT = 1'b1;
            busy_left--;
         end else begin
            bus.MEM_BUSYWAIT = 1'b0;
            if (bus.MEM_WRITE) mem_line[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
            else               bus.MEM_READDATA = mem_get(bus.MEM_ADDRESS);
            busy_left = pick_busy();
         end
      end
   end

   // monitor: pops the scoreboard whenever a transfer or a load completes
   initial begin
      forever begin
         @(negedge clk); #1;
         check("mem_rw_exclusive", {127'd0, bus.MEM_READ & bus.MEM_WRITE}, 128'd0);
         if (!rst_n || !bus.DATA_MEM_READ[3] || bus.DATA_MEM_BUSYWAIT)
            check("read_data_zero", {96'd0, bus.DATA_MEM_READ_DATA}, 128'd0);
         if (rst_n && bus.MEM_WRITE && !bus.MEM_BUSYWAIT)
            pop_check(K_WB, bus.MEM_ADDRESS, bus.MEM_WRITEDATA);
         if (rst_n && bus.MEM_READ && !bus.MEM_BUSYWAIT)
            pop_check(K_FILL, bus.MEM_ADDRESS, '0);
         if (rst_n && bus.DATA_MEM_READ[3] && !bus.DATA_MEM_WRITE[2] && !bus.DATA_MEM_BUSYWAIT)
            pop_check(K_LOAD, '0, {96'd0, bus.DATA_MEM_READ_DATA});
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int           w;
      logic [31:0]  r, a, wd;
      logic [127:0] l;
      logic [24:0]  tag;
      bit           seen;
      bit           rd, wr;
      logic [2:0]   f3;
      logic [1:0]   sz;
      int           op;

      drive_idle();
      for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_blk[i] = '0; end

      // reset for two cycles, then idle outputs
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1; #1;
      check("idle_busywait",  {127'd0, bus.DATA_MEM_BUSYWAIT}, 128'd0);
      check("idle_mem_read",  {127'd0, bus.MEM_READ}, 128'd0);
      check("idle_mem_write", {127'd0, bus.MEM_WRITE}, 128'd0);
      check("idle_read_data", {96'd0, bus.DATA_MEM_READ_DATA}, 128'd0);

      l = init_line(28'h4);     l[63:32] = 32'hDEADBEEF; mem_line[28'h4]  = l;
      l = init_line(28'h10);    l[31:0]  = 32'h0000_8F80; mem_line[28'h10] = l;

      // clean read miss with three busy memory cycles
      busy_cfg = 3;
      do_access(1, 0, 3'b010, 2'b00, 32'h44, 32'h0, w, r);
      check("clean_miss_data", {96'd0, r}, {96'd0, 32'hDEADBEEF});
      check("clean_miss_stall", w, 5);

      // store merge on a hit, then dirty eviction
      busy_cfg = -1;
      do_access(0, 1, 3'b000, 2'b00, 32'h45, 32'h0000_00AA, w, r);
      check("store_hit_no_stall", w, 0);
      do_access(1, 0, 3'b010, 2'b00, 32'h44, 32'h0, w, r);
      check("store_merge", {96'd0, r}, {96'd0, 32'hDEADAAEF});
      do_access(1, 0, 3'b010, 2'b00, 32'hC4, 32'h0, w, r);

      // sign / zero extension
      do_access(1, 0, 3'b000, 2'b00, 32'h100, 32'h0, w, r);
      check("ext_lb", {96'd0, r}, {96'd0, 32'hFFFF_FF80});
      do_access(1, 0, 3'b100, 2'b00, 32'h100, 32'h0, w, r);
      check("ext_lbu", {96'd0, r}, {96'd0, 32'h0000_0080});
      do_access(1, 0, 3'b001, 2'b00, 32'h100, 32'h0, w, r);
      check("ext_lh", {96'd0, r}, {96'd0, 32'hFFFF_8F80});
      do_access(1, 0, 3'b101, 2'b00, 32'h100, 32'h0, w, r);
      check("ext_lhu", {96'd0, r}, {96'd0, 32'h0000_8F80});

      // clean miss with memory ready immediately
      busy_cfg = 0;
      do_access(1, 0, 3'b010, 2'b00, 32'h200, 32'h0, w, r);
      check("min_miss_stall", w, 2);

      // reset while refill is outstanding
      busy_cfg = 6;
      model_issue(1, 0, 3'b010, 2'b00, 32'h3F0, 32'h0);
      @(posedge clk); #1;
      bus.DATA_MEM_READ = 4'b1010; bus.DATA_MEM_WRITE = 3'd0; bus.DATA_MEM_ADDR = 32'h3F0;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk); #1;
         if (bus.MEM_READ) begin seen = 1'b1; break; end
      end
      check("alloc_reached", {127'd0, seen}, 128'd1);
      #1 rst_n = 1'b0; #1;
      check("rst_mem_read",  {127'd0, bus.MEM_READ}, 128'd0);
      check("rst_busywait",  {127'd0, bus.DATA_MEM_BUSYWAIT}, 128'd0);
      check("rst_read_data", {96'd0, bus.DATA_MEM_READ_DATA}, 128'd0);
      model_reset();
      @(posedge clk); #1; drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      busy_cfg = 0;
      do_access(1, 0, 3'b010, 2'b00, 32'h3F0, 32'h0, w, r);
      check("reissue_misses", w, 2);

      // randomized traffic over a few conflicting tags
      busy_cfg = -1;
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 3))
            0:       tag = 25'd0;
            1:       tag = 25'd1;
            2:       tag = 25'd2;
            default: tag = 25'h1ABCDEF;
         endcase
         a  = {tag, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
         wd = $urandom;
         op = int'($urandom_range(0, 9));
         case ($urandom_range(0, 7))
            0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
            4: f3 = 3'd5; 5: f3 = 3'd2; 6: f3 = 3'd3; default: f3 = 3'd6;
         endcase
         sz = 2'($urandom_range(0, 2));
         rd = (op <= 4) || (op == 9);
         wr = (op >= 5);
         do_access(rd, wr, f3, sz, a, wd, w, r);
      end

      @(posedge clk); #1; drive_idle();
      repeat (20) @(posedge clk);
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
